// File: rtl/camera_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : camera_stream_if
// Description : Control, pixel-source handshake and camera-bus signals of the
//               camera stream transmitter, grouped into one bundle.
//   enable        run frames while high
//   pattern_sel   0 colour bars, 1 gradient, 2 external, 3 solid
//   pix_data      external RGB565 pixel
//   pix_valid     pix_data is valid
//   pix_ready     one-clk pulse: pixel consumed when pix_valid is high
//   clr_underrun  clears the sticky underrun flag
//   camera_export [15:0] pixel, [16] pclk, [17] href, [18] vsync, [25:19] 0
//   frame_start   one-clk pulse at the vsync rise
//   frame_count   frames started, wraps
//   underrun      sticky: an external pixel was missing
//   master : transmitter side, slave : environment / pixel source side
// Revision    : 1.0 - initial release
// ============================================================================
interface camera_stream_if;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        clr_underrun;
   logic [25:0] camera_export;
   logic        frame_start;
   logic [15:0] frame_count;
   logic        underrun;

   modport master (
      input  enable, pattern_sel, pix_data, pix_valid, clr_underrun,
      output pix_ready, camera_export, frame_start, frame_count, underrun
   );

   modport slave (
      output enable, pattern_sel, pix_data, pix_valid, clr_underrun,
      input  pix_ready, camera_export, frame_start, frame_count, underrun
   );
endinterface
`default_nettype wire

// File: rtl/camera_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : camera_stream_tx
// Description : Parallel camera-bus transmitter. Produces pclk/href/vsync
//               timing and RGB565 pixels from built-in test patterns or from
//               an external valid/ready pixel source.
//   clk_clk     system clock
//   reset_reset synchronous, active-low reset
//   bus         camera_stream_if.master (control, pixel source, camera bus,
//               frame_start, frame_count, underrun)
// Revision    : 1.0 - initial release
// ============================================================================
module camera_stream_tx #(
   parameter int          H_ACTIVE    = 640,
   parameter int          H_BLANK     = 144,
   parameter int          V_SYNC      = 3,
   parameter int          V_BACK      = 17,
   parameter int          V_ACTIVE    = 480,
   parameter int          V_FRONT     = 10,
   parameter int          CLK_DIV     = 1,
   parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
   input  logic            clk_clk,
   input  logic            reset_reset,
   camera_stream_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_MAX1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
   localparam int V_MAX2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int V_MAX   = (V_MAX1 > V_MAX2) ? V_MAX1 : V_MAX2;
   localparam int LINE_W  = (V_MAX > 1) ? $clog2(V_MAX) : 1;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBACK  = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFRONT = 3'd4
   } state_t;

   state_t              state, next_state;
   logic [DIV_W-1:0]    div_cnt;
   logic                pclk;
   logic [H_W-1:0]      h_cnt;      // tick position within the line
   logic [LINE_W-1:0]   line_cnt;   // line within the current region
   logic [2:0]          bar_idx;    // colour bar of the current x
   logic [BAR_CW-1:0]   bar_sub;    // pixel within the current bar
   logic [1:0]          pattern;    // pattern latched for the whole frame
   logic [15:0]         pixel;
   logic                href;
   logic                vsync;
   logic                frame_start;
   logic [15:0]         frame_count;
   logic                underrun;

   logic                tick;
   logic                line_end;
   logic                region_end;
   logic                active_pix;
   logic                ext_req;
   int                  region_len;
   logic [15:0]         gen_pixel;

   // Counters describe the position that the next tick puts on the bus.
   always_comb begin
      case (state)
         S_VBACK:  region_len = V_BACK;
         S_ACTIVE: region_len = V_ACTIVE;
         S_VFRONT: region_len = V_FRONT;
         default:  region_len = V_SYNC;
      endcase
      tick       = (state != S_IDLE) && pclk && (int'(div_cnt) == CLK_DIV - 1);
      line_end   = (int'(h_cnt) == H_TOTAL - 1);
      region_end = line_end && (int'(line_cnt) == region_len - 1);
      active_pix = (state == S_ACTIVE) && (int'(h_cnt) < H_ACTIVE);
      // Gated by reset so no pixel is requested or consumed while in reset.
      ext_req    = tick && active_pix && (pattern == 2'd2) && reset_reset;
   end

   always_comb begin
      gen_pixel = 16'h0000;
      if (active_pix) begin
         case (pattern)
            2'd0: begin
               case (bar_idx)
                  3'd0:    gen_pixel = 16'hFFFF;
                  3'd1:    gen_pixel = 16'hFFE0;
                  3'd2:    gen_pixel = 16'h07FF;
                  3'd3:    gen_pixel = 16'h07E0;
                  3'd4:    gen_pixel = 16'hF81F;
                  3'd5:    gen_pixel = 16'hF800;
                  3'd6:    gen_pixel = 16'h001F;
                  default: gen_pixel = 16'h0000;
               endcase
            end
            2'd1:    gen_pixel = 16'(h_cnt) + 16'(line_cnt);
            2'd2:    gen_pixel = bus.pix_valid ? bus.pix_data : 16'h0000;
            default: gen_pixel = SOLID_COLOR;
         endcase
      end
   end

   // Frame state advances only on the tick that ends a region's last line.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (bus.enable) next_state = S_VSYNC;
         S_VSYNC:  if (tick && region_end)
                      next_state = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
         S_VBACK:  if (tick && region_end) next_state = S_ACTIVE;
         S_ACTIVE: if (tick && region_end)
                      next_state = (V_FRONT > 0) ? S_VFRONT :
                                   (bus.enable ? S_VSYNC : S_IDLE);
         S_VFRONT: if (tick && region_end)
                      next_state = bus.enable ? S_VSYNC : S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset) state <= S_IDLE;
      else              state <= next_state;
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset) begin
         div_cnt     <= '0;
         pclk        <= 1'b0;
         h_cnt       <= '0;
         line_cnt    <= '0;
         bar_idx     <= 3'd0;
         bar_sub     <= '0;
         pattern     <= 2'd0;
         pixel       <= 16'h0000;
         href        <= 1'b0;
         vsync       <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= 16'h0000;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         // A miss on the same clk as a clear keeps the flag set.
         if (ext_req && !bus.pix_valid) underrun <= 1'b1;
         else if (bus.clr_underrun)      underrun <= 1'b0;

         if (state == S_IDLE) begin
            // pclk starts high on the clk that leaves IDLE.
            pclk     <= bus.enable;
            div_cnt  <= '0;
            h_cnt    <= '0;
            line_cnt <= '0;
            bar_idx  <= 3'd0;
            bar_sub  <= '0;
            pixel    <= 16'h0000;
            href     <= 1'b0;
            vsync    <= 1'b0;
         end else begin
            if (int'(div_cnt) == CLK_DIV - 1) begin
               div_cnt <= '0;
               pclk    <= ~pclk;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end

            if (tick) begin
               pixel <= gen_pixel;
               href  <= active_pix;
               vsync <= (state == S_VSYNC);
               if (state == S_VSYNC && line_cnt == '0 && h_cnt == '0) begin
                  frame_start <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  pattern     <= bus.pattern_sel;
               end
               if (line_end) begin
                  h_cnt    <= '0;
                  bar_idx  <= 3'd0;
                  bar_sub  <= '0;
                  line_cnt <= region_end ? '0 : line_cnt + 1'b1;
               end else begin
                  h_cnt <= h_cnt + 1'b1;
                  if (int'(bar_sub) == BAR_W - 1) begin
                     bar_sub <= '0;
                     bar_idx <= bar_idx + 3'd1;
                  end else begin
                     bar_sub <= bar_sub + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus.camera_export = {7'b0, vsync, href, pclk, pixel};
   assign bus.pix_ready     = ext_req;
   assign bus.frame_start   = frame_start;
   assign bus.frame_count   = frame_count;
   assign bus.underrun      = underrun;

endmodule
`default_nettype wire
